sample_store: RTL and testbench

Parametrised capture buffer between the data aligner and the readback path. It packs samples of 1, 2 or all enabled byte-groups into LANES-wide memory words, filling each word before advancing the address. It then replays the captured slots, newest-first or oldest-first, over a stallable valid/ready port. Unlike the fixed 4-lane store, it has a wrap flag, a fill counter, stall-safe readback with `rd_last`, and a selectable read direction.

---
 rtl/sample_store_pkg.sv | 36 +++
 rtl/sample_store_if.sv | 36 +++
 rtl/sample_store_ram.sv | 23 ++
 rtl/sample_store.sv | 246 ++++++++++++++++++++++++
 tb/tb_sample_store.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sample_store_pkg.sv
// Shared types and configuration helpers for the sample_store capture buffer.
package sample_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int MAX_LANES = 8;

  function automatic logic [3:0] popcount8(input logic [MAX_LANES-1:0] g);
    popcount8 = '0;
    for (int i = 0; i < MAX_LANES; i++) popcount8 = popcount8 + {3'b000, g[i]};
  endfunction

  // Lanes per sample: one or two groups pack narrow, anything else (incl. none) uses the full word.
  function automatic logic [3:0] slot_lanes(input logic [MAX_LANES-1:0] groups, input int lanes);
    logic [3:0] k;
    k = popcount8(groups);
    if (k == 4'd1)      slot_lanes = 4'd1;
    else if (k == 4'd2) slot_lanes = 4'd2;
    else                slot_lanes = 4'(lanes);
  endfunction

  function automatic logic [MAX_LANES-1:0] keep_mask(input logic [MAX_LANES-1:0] groups,
                                                     input int lanes);
    logic [3:0] k;
    logic [3:0] p;
    k = popcount8(groups);
    p = slot_lanes(groups, lanes);
    if (lanes == 4 && k == 4'd3) keep_mask = 8'h07;
    else                         keep_mask = 8'((9'd1 << p) - 9'd1);
  endfunction

endpackage

// File: rtl/sample_store_if.sv
// Configuration, capture and readback signals of sample_store grouped as one bundle.
interface sample_store_if #(
  parameter int LANES = 4,
  parameter int LW    = 8
);
  import sample_store_pkg::*;

  logic                  cfg_wr;
  logic [LANES-1:0]      cfg_groups;
  logic                  cfg_reverse;
  logic                  wr_valid;
  logic                  wr_last;
  logic [LANES*LW-1:0]   wr_data;
  logic                  rd_start;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [LANES*LW-1:0]   rd_data;
  logic [LANES-1:0]      rd_keep;
  logic                  rd_last;
  logic                  wrapped;
  logic                  busy;
  state_t                state_dbg;

  // Readback handshake: a slot moves on a cycle with rd_valid & rd_ready; while rd_valid is
  // high and rd_ready low, rd_data/rd_keep/rd_last hold and rd_valid never drops except on cfg_wr.
  modport master (
    output cfg_wr, cfg_groups, cfg_reverse, wr_valid, wr_last, wr_data, rd_start, rd_ready,
    input  rd_valid, rd_data, rd_keep, rd_last, wrapped, busy, state_dbg
  );

  modport slave (
    input  cfg_wr, cfg_groups, cfg_reverse, wr_valid, wr_last, wr_data, rd_start, rd_ready,
    output rd_valid, rd_data, rd_keep, rd_last, wrapped, busy, state_dbg
  );

endinterface

// File: rtl/sample_store_ram.sv
// One byte lane of sample storage: single-port RAM with registered read.
module sample_store_ram
  import sample_store_pkg::*;
#(
  parameter int LW    = 8,
  parameter int DEPTH = 6144,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] din,
  output logic [LW-1:0] dout
);

  logic [LW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/sample_store.sv
// Capture buffer: packs 1/2/LANES-lane samples into memory words, then replays them
// newest- or oldest-first through an output register plus one-entry skid buffer.
module sample_store
  import sample_store_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = 8,
  parameter int DEPTH = 6144,
  parameter int AW    = 13
) (
  input logic           clk,
  input logic           rst_n,
  sample_store_if.slave bus
);

  localparam int LIW = $clog2(LANES);
  localparam int CW  = AW + LIW + 1;
  localparam int DW  = LANES * LW;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [LIW:0]   LANES_W   = (LIW+1)'(LANES);
  localparam logic [CW-1:0]  N_P1      = CW'(DEPTH * LANES);
  localparam logic [CW-1:0]  N_P2      = CW'(DEPTH * LANES / 2);
  localparam logic [CW-1:0]  N_PL      = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [LIW-1:0] lane;
  } slot_ptr_t;

  function automatic slot_ptr_t step(input slot_ptr_t s, input logic rev, input logic [LIW:0] p);
    logic [LIW:0] sum;
    sum  = '0;
    step = s;
    if (!rev) begin
      sum = {1'b0, s.lane} + p;
      if (sum == LANES_W) begin
        step.lane = '0;
        step.addr = (s.addr == LAST_ADDR) ? '0 : s.addr + AW'(1);
      end else begin
        step.lane = sum[LIW-1:0];
      end
    end else if (s.lane == '0) begin
      sum       = LANES_W - p;
      step.lane = sum[LIW-1:0];
      step.addr = (s.addr == '0) ? LAST_ADDR : s.addr - AW'(1);
    end else begin
      step.lane = s.lane - p[LIW-1:0];
    end
  endfunction

  state_t          state, state_nx;
  logic [LIW:0]    p_lanes;
  logic [LANES-1:0] keep_r;
  logic [CW-1:0]   n_slots, count, remain;
  logic            wrapped_r, rd_rev;
  slot_ptr_t       wp, lp, op, rp;

  logic            ram_vld, ram_last;
  logic [LIW-1:0]  ram_lane;
  logic            out_vld, out_last;
  logic [DW-1:0]   out_data;
  logic            skid_vld, skid_last;
  logic [DW-1:0]   skid_data;

  logic [MAX_LANES-1:0] groups8;
  logic [LIW:0]    p_cfg;
  logic [CW-1:0]   n_cfg;
  logic            transfer, start_ok, drain_issue, issue_last, fill_write;
  logic [1:0]      held;
  slot_ptr_t       start_ptr, issue_ptr;
  logic [AW-1:0]   ram_addr;
  logic [LIW-1:0]  align_mask, src;
  logic [LANES-1:0] lane_we;
  logic [DW-1:0]   wr_rep, ram_slot;
  logic [LW-1:0]   lane_q [LANES];

  always_comb begin
    groups8 = '0;
    groups8[LANES-1:0] = bus.cfg_groups;
    p_cfg = (LIW+1)'(slot_lanes(groups8, LANES));
    if (p_cfg == (LIW+1)'(1))  n_cfg = N_P1;
    else if (p_cfg == LANES_W) n_cfg = N_PL;
    else                       n_cfg = N_P2;
  end

  // Credit: at most two slots may be held between the RAM output, out register and skid.
  always_comb begin
    transfer    = out_vld & bus.rd_ready;
    held        = 2'(ram_vld) + 2'(out_vld) + 2'(skid_vld) - 2'(transfer);
    start_ptr   = bus.cfg_reverse ? lp : op;
    start_ok    = (state == ST_IDLE) && bus.rd_start && (count != '0) && !bus.cfg_wr;
    drain_issue = (state == ST_DRAIN) && (remain != '0) && (held < 2'd2) && !bus.cfg_wr;
    issue_ptr   = start_ok ? start_ptr : rp;
    issue_last  = start_ok ? (count == CW'(1)) : (remain == CW'(1));
    fill_write  = (state == ST_FILL) && bus.wr_valid && !bus.cfg_wr;
    ram_addr    = (state == ST_FILL) ? wp.addr : issue_ptr.addr;
  end

  always_comb begin
    lane_we    = '0;
    wr_rep     = '0;
    align_mask = ~(p_lanes[LIW-1:0] - LIW'(1));
    for (int i = 0; i < LANES; i++) begin
      lane_we[i]          = fill_write && ((LIW'(i) & align_mask) == wp.lane);
      wr_rep[i*LW +: LW]  = bus.wr_data[int'(LIW'(i) & ~align_mask)*LW +: LW];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sample_store_ram #(.LW(LW), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk  (clk),
      .we   (lane_we[g]),
      .addr (ram_addr),
      .din  (wr_rep[g*LW +: LW]),
      .dout (lane_q[g])
    );
  end

  always_comb begin
    ram_slot = '0;
    src      = '0;
    for (int i = 0; i < LANES; i++) begin
      src = ram_lane + LIW'(i);
      if (i < int'(p_lanes)) ram_slot[i*LW +: LW] = lane_q[src];
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.cfg_wr) begin
      state_nx = ST_FILL;
    end else begin
      case (state)
        ST_IDLE:  if (start_ok) state_nx = ST_DRAIN;
        ST_FILL:  if (bus.wr_valid && bus.wr_last) state_nx = ST_IDLE;
        ST_DRAIN: if (transfer && out_last) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_lanes   <= LANES_W;
      keep_r    <= '1;
      n_slots   <= N_PL;
      count     <= '0;
      wrapped_r <= 1'b0;
      wp        <= '0;
      lp        <= '0;
      op        <= '0;
      rp        <= '0;
      remain    <= '0;
      rd_rev    <= 1'b0;
    end else if (bus.cfg_wr) begin
      p_lanes   <= p_cfg;
      keep_r    <= LANES'(keep_mask(groups8, LANES));
      n_slots   <= n_cfg;
      count     <= '0;
      wrapped_r <= 1'b0;
      wp        <= '0;
      lp        <= '0;
      op        <= '0;
      rp        <= '0;
      remain    <= '0;
    end else begin
      if (fill_write) begin
        wp <= step(wp, 1'b0, p_lanes);
        lp <= wp;
        // Once full, every write retires the oldest slot, so oldest follows the write pointer.
        if (count == n_slots) begin
          wrapped_r <= 1'b1;
          op        <= step(wp, 1'b0, p_lanes);
        end else begin
          count <= count + CW'(1);
        end
      end
      if (start_ok) begin
        rp     <= step(start_ptr, bus.cfg_reverse, p_lanes);
        remain <= count - CW'(1);
        rd_rev <= bus.cfg_reverse;
      end else if (drain_issue) begin
        rp     <= step(rp, rd_rev, p_lanes);
        remain <= remain - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      ram_lane  <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
    end else if (bus.cfg_wr) begin
      ram_vld  <= 1'b0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      ram_vld <= start_ok | drain_issue;
      if (start_ok | drain_issue) begin
        ram_last <= issue_last;
        ram_lane <= issue_ptr.lane;
      end
      if (!out_vld || transfer) begin
        if (skid_vld) begin
          out_vld   <= 1'b1;
          out_data  <= skid_data;
          out_last  <= skid_last;
          skid_vld  <= ram_vld;
          skid_data <= ram_slot;
          skid_last <= ram_last;
        end else if (ram_vld) begin
          out_vld  <= 1'b1;
          out_data <= ram_slot;
          out_last <= ram_last;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (ram_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= ram_slot;
        skid_last <= ram_last;
      end
    end
  end

  assign bus.rd_valid  = out_vld;
  assign bus.rd_data   = out_data;
  assign bus.rd_keep   = out_vld ? keep_r : '0;
  assign bus.rd_last   = out_vld & out_last;
  assign bus.wrapped   = wrapped_r;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sample_store.sv
// Directed bench for sample_store (LANES=4, DEPTH=4) with a queue of expected readback slots.
module tb_sample_store;
  import sample_store_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_q [$];

  sample_store_if #(.LANES(4), .LW(8)) bus ();

  sample_store #(.LANES(4), .LW(8), .DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic do_cfg(input logic [3:0] g, input logic rev);
    bus.cfg_wr = 1'b1; bus.cfg_groups = g; bus.cfg_reverse = rev;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] d, input logic last);
    bus.wr_valid = 1'b1; bus.wr_data = d; bus.wr_last = last;
    tick();
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
  endtask

  // Read back everything in exp_q; optionally hold rd_ready low for stall_len valid cycles
  // once stall_after slots have been taken.
  task automatic drain(input string tag, input logic [3:0] keep_exp,
                       input int stall_after, input int stall_len);
    int cyc, got, first, n, stall_cnt;
    logic seen;
    logic [31:0] held, e;
    n = exp_q.size(); got = 0; first = 0; stall_cnt = 0; seen = 1'b0; held = '0;
    bus.rd_ready = 1'b1;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    cyc = 1;
    while (exp_q.size() != 0 && cyc < 100) begin
      if (bus.rd_valid && !seen) begin seen = 1'b1; first = cyc; end
      if (bus.rd_valid && got == stall_after && stall_cnt < stall_len) begin
        bus.rd_ready = 1'b0;
        if (stall_cnt == 0) held = bus.rd_data;
        else check({tag, "_hold"}, bus.rd_data, held);
        stall_cnt++;
      end else begin
        bus.rd_ready = 1'b1;
        if (bus.rd_valid) begin
          e = exp_q.pop_front();
          got++;
          check({tag, "_data"}, bus.rd_data, e);
          check({tag, "_keep"}, {28'h0, bus.rd_keep}, {28'h0, keep_exp});
          check({tag, "_last"}, {31'h0, bus.rd_last}, {31'h0, exp_q.size() == 0});
        end
      end
      tick();
      cyc++;
    end
    exp_q.delete();
    bus.rd_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_lat"}, 32'(first), 32'd2);
    if (stall_len == 0) check({tag, "_rate"}, 32'(cyc - first), 32'(n));
    check({tag, "_vld_end"}, {31'h0, bus.rd_valid}, 32'h0);
    check({tag, "_busy_end"}, {31'h0, bus.busy}, 32'h0);
  endtask

  initial begin
    logic any_v;
    rst_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_groups = '0; bus.cfg_reverse = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_data = '0;
    bus.rd_start = 1'b0; bus.rd_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'h0, bus.rd_valid}, 32'h0);
    check("rst_keep", {28'h0, bus.rd_keep}, 32'h0);
    check("rst_last", {31'h0, bus.rd_last}, 32'h0);
    check("rst_data", bus.rd_data, 32'h0);
    check("rst_wrapped", {31'h0, bus.wrapped}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // rd_start with nothing captured
    any_v = 1'b0;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    repeat (4) begin any_v |= bus.rd_valid; tick(); end
    check("empty_valid", {31'h0, any_v}, 32'h0);
    check("empty_busy", {31'h0, bus.busy}, 32'h0);

    // full-width samples, newest first
    do_cfg(4'b1111, 1'b1);
    check("t1_busy_fill", {31'h0, bus.busy}, 32'h1);
    do_wr(32'h11223344, 1'b0);
    do_wr(32'hAABBCCDD, 1'b1);
    check("t1_idle", {31'h0, bus.busy}, 32'h0);
    check("t1_wrapped", {31'h0, bus.wrapped}, 32'h0);
    exp_q.push_back(32'hAABBCCDD);
    exp_q.push_back(32'h11223344);
    drain("t1", 4'hF, -1, 0);

    // single-lane samples, reverse; upper bytes of wr_data must be ignored
    do_cfg(4'b0001, 1'b1);
    for (int i = 1; i <= 6; i++) do_wr(32'hFFFFFF00 | 32'(i), i == 6);
    for (int i = 6; i >= 1; i--) exp_q.push_back(32'(i));
    drain("t2r", 4'b0001, -1, 0);

    // same capture, oldest first, with a 5-cycle consumer stall
    do_cfg(4'b0001, 1'b0);
    for (int i = 1; i <= 6; i++) do_wr(32'hFFFFFF00 | 32'(i), i == 6);
    for (int i = 1; i <= 6; i++) exp_q.push_back(32'(i));
    drain("t2f", 4'b0001, 2, 5);

    // two-lane samples overflowing 8 slots
    do_cfg(4'b0011, 1'b1);
    check("t3_wrap_clr", {31'h0, bus.wrapped}, 32'h0);
    for (int i = 0; i < 10; i++) do_wr({16'hBEEF, 16'hA000 + 16'(i)}, i == 9);
    check("t3_wrapped", {31'h0, bus.wrapped}, 32'h1);
    for (int i = 9; i >= 2; i--) exp_q.push_back(32'hA000 + 32'(i));
    drain("t3r", 4'b0011, -1, 0);

    do_cfg(4'b0011, 1'b0);
    for (int i = 0; i < 10; i++) do_wr({16'hBEEF, 16'hA000 + 16'(i)}, i == 9);
    for (int i = 2; i <= 9; i++) exp_q.push_back(32'hA000 + 32'(i));
    drain("t3f", 4'b0011, 1, 3);

    // exactly full is not wrapped; cfg_wr aborts a stalled drain and drops a same-cycle sample
    do_cfg(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) do_wr(32'h01010101 * 32'(i + 1), i == 3);
    check("t4_full_nowrap", {31'h0, bus.wrapped}, 32'h0);
    bus.rd_ready = 1'b0;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    tick();
    check("t4_pre_valid", {31'h0, bus.rd_valid}, 32'h1);
    check("t4_pre_data", bus.rd_data, 32'h01010101);
    bus.cfg_wr = 1'b1; bus.cfg_groups = 4'b1111; bus.cfg_reverse = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = 32'h99999999;
    tick();
    bus.cfg_wr = 1'b0; bus.wr_valid = 1'b0;
    check("t4_abort_valid", {31'h0, bus.rd_valid}, 32'h0);
    check("t4_abort_busy", {31'h0, bus.busy}, 32'h1);
    check("t4_abort_state", 32'(bus.state_dbg), 32'(ST_FILL));
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    tick(); tick();
    check("t4_fill_start_valid", {31'h0, bus.rd_valid}, 32'h0);
    check("t4_fill_start_state", 32'(bus.state_dbg), 32'(ST_FILL));
    do_wr(32'h12345678, 1'b1);
    exp_q.push_back(32'h12345678);
    drain("t4", 4'hF, -1, 0);

    // three groups on four lanes
    do_cfg(4'b0111, 1'b0);
    do_wr(32'h00A1B2C3, 1'b0);
    do_wr(32'hFFD4E5F6, 1'b1);
    exp_q.push_back(32'h00A1B2C3);
    exp_q.push_back(32'hFFD4E5F6);
    drain("t5", 4'b0111, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
